// File: rtl/mul_arb_pkg.sv
// Shared types and helpers for the two-port round-robin multiplier arbiter.
package mul_arb_pkg;

  // Number of requesters sharing the multiplier and width of the id tag.
  localparam int N_REQ = 2;
  localparam int ID_W  = 1;

  // Default operand width used when the block is built without an override.
  localparam int MUL_N = 8;

  // One queued multiply operation at the default operand width.
  typedef struct packed {
    logic [MUL_N-1:0] a;
    logic [MUL_N-1:0] b;
    logic             signed_mul;
    logic [ID_W-1:0]  id;
  } mul_op_t;

  // Winner of a tie: the requester that was not granted last time.
  function automatic logic [ID_W-1:0] rr_tie_winner(input logic [ID_W-1:0] last);
    return ~last;
  endfunction

endpackage

// File: rtl/mul_rr_arbiter_mul.sv
// Combinational n x n multiplier with a signed/unsigned operand mode.
// Both operands are extended to 2*n bits (sign or zero) and multiplied at
// 2*n bits; the low 2*n bits of that product are exact in either mode.
module signed_or_unsigned_mul #(
  parameter int n = 8
) (
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  input  logic           signed_mul,
  output logic [2*n-1:0] product
);

  logic [2*n-1:0] w_a_ext;
  logic [2*n-1:0] w_b_ext;

  // Extend both operands to the product width according to the mode.
  always_comb begin
    w_a_ext = {{n{1'b0}}, a};
    w_b_ext = {{n{1'b0}}, b};
    if (signed_mul) begin
      w_a_ext = {{n{a[n-1]}}, a};
      w_b_ext = {{n{b[n-1]}}, b};
    end else begin
      w_a_ext = {{n{1'b0}}, a};
      w_b_ext = {{n{1'b0}}, b};
    end
  end

  assign product = w_a_ext * w_b_ext;

endmodule

// File: rtl/mul_rr_arbiter.sv
// Two requesters share one multiplier through a round-robin arbiter and a
// two-stage pipeline (operand register, result register). Results carry the
// id of the requester that issued them and leave in acceptance order.
module mul_rr_arbiter
  import mul_arb_pkg::*;
#(
  parameter int n = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_vld,
  output logic           req0_rdy,
  input  logic [n-1:0]   req0_a,
  input  logic [n-1:0]   req0_b,
  input  logic           req0_signed,
  input  logic           req1_vld,
  output logic           req1_rdy,
  input  logic [n-1:0]   req1_a,
  input  logic [n-1:0]   req1_b,
  input  logic           req1_signed,
  output logic           res_vld,
  input  logic           res_rdy,
  output logic [2*n-1:0] res,
  output logic [ID_W-1:0] res_id
);

  // Operand-stage payload at this instance's operand width.
  typedef struct packed {
    logic [n-1:0]    a;
    logic [n-1:0]    b;
    logic            signed_mul;
    logic [ID_W-1:0] id;
  } op_t;

  // Pipeline state.
  logic            r_s1_vld;
  op_t             r_s1;
  logic            r_res_vld;
  logic [2*n-1:0]  r_res;
  logic [ID_W-1:0] r_res_id;
  logic [ID_W-1:0] r_last;

  // Combinational control and datapath.
  logic [N_REQ-1:0] w_vld;
  logic             w_s2_free;
  logic             w_s1_free;
  logic             w_gnt_vld;
  logic [ID_W-1:0]  w_gnt_id;
  op_t              w_op;
  logic [2*n-1:0]   w_product;

  assign w_vld     = {req1_vld, req0_vld};
  assign w_s2_free = !r_res_vld | res_rdy;
  assign w_s1_free = !r_s1_vld | w_s2_free;

  // Round-robin grant; only considered while the operand stage can load.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = 1'b0;
    if (w_s1_free) begin
      case (w_vld)
        2'b01: begin
          w_gnt_vld = 1'b1;
          w_gnt_id  = 1'b0;
        end
        2'b10: begin
          w_gnt_vld = 1'b1;
          w_gnt_id  = 1'b1;
        end
        2'b11: begin
          w_gnt_vld = 1'b1;
          w_gnt_id  = rr_tie_winner(r_last);
        end
        default: begin
          w_gnt_vld = 1'b0;
          w_gnt_id  = 1'b0;
        end
      endcase
    end else begin
      w_gnt_vld = 1'b0;
      w_gnt_id  = 1'b0;
    end
  end

  // Select the granted requester's operands for the operand stage.
  always_comb begin
    w_op = '0;
    if (w_gnt_id == 1'b1) begin
      w_op.a          = req1_a;
      w_op.b          = req1_b;
      w_op.signed_mul = req1_signed;
      w_op.id         = 1'b1;
    end else begin
      w_op.a          = req0_a;
      w_op.b          = req0_b;
      w_op.signed_mul = req0_signed;
      w_op.id         = 1'b0;
    end
  end

  // Ready depends only on pipeline state and the valids, never on operands.
  assign req0_rdy = w_gnt_vld & (w_gnt_id == 1'b0);
  assign req1_rdy = w_gnt_vld & (w_gnt_id == 1'b1);

  // Operand stage and round-robin pointer: load on accept, drain when s2 takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s1     <= '0;
      r_last   <= 1'b1;
    end else if (w_gnt_vld) begin
      r_s1_vld <= 1'b1;
      r_s1     <= w_op;
      r_last   <= w_gnt_id;
    end else if (w_s2_free) begin
      r_s1_vld <= 1'b0;
    end
  end

  signed_or_unsigned_mul #(
    .n(n)
  ) u_mul (
    .a         (r_s1.a),
    .b         (r_s1.b),
    .signed_mul(r_s1.signed_mul),
    .product   (w_product)
  );

  // Result stage: capture the product when free, hold it stable under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_vld <= 1'b0;
      r_res     <= '0;
      r_res_id  <= 1'b0;
    end else if (w_s2_free && r_s1_vld) begin
      r_res_vld <= 1'b1;
      r_res     <= w_product;
      r_res_id  <= r_s1.id;
    end else if (res_rdy) begin
      r_res_vld <= 1'b0;
    end
  end

  assign res_vld = r_res_vld;
  assign res     = r_res;
  assign res_id  = r_res_id;

endmodule

// File: tb/tb_mul_rr_arbiter.sv
// Self-checking bench for mul_rr_arbiter: a cycle model predicts grants and
// stage occupancy, a scoreboard holds expected results in acceptance order.
module tb_mul_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_vld, req0_rdy, req0_signed;
  logic [7:0]  req0_a, req0_b;
  logic        req1_vld, req1_rdy, req1_signed;
  logic [7:0]  req1_a, req1_b;
  logic        res_vld, res_rdy;
  logic [15:0] res;
  logic        res_id;

  mul_rr_arbiter #(.n(8)) dut (
    .clk(clk), .rst(rst),
    .req0_vld(req0_vld), .req0_rdy(req0_rdy), .req0_a(req0_a), .req0_b(req0_b),
    .req0_signed(req0_signed),
    .req1_vld(req1_vld), .req1_rdy(req1_rdy), .req1_a(req1_a), .req1_b(req1_b),
    .req1_signed(req1_signed),
    .res_vld(res_vld), .res_rdy(res_rdy), .res(res), .res_id(res_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sg;
    logic [15:0] exp;
  } op_t;

  typedef struct {
    logic [15:0] res;
    logic        id;
    int          acc;
    logic        lat;
  } sb_t;

  op_t q0[$];
  op_t q1[$];
  sb_t sb[$];

  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  logic lat_mode = 1'b0;
  logic m_s1 = 1'b0;
  logic m_s2 = 1'b0;
  logic m_last = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic sg);
    int x, y, p;
    x = sg ? int'($signed(a)) : int'(a);
    y = sg ? int'($signed(b)) : int'(b);
    p = x * y;
    return p[15:0];
  endfunction

  task automatic push(input int r, input logic [7:0] a, input logic [7:0] b,
                      input logic sg, input logic [15:0] exp);
    op_t o;
    o.a = a; o.b = b; o.sg = sg; o.exp = exp;
    if (r == 0) q0.push_back(o);
    else q1.push_back(o);
  endtask

  task automatic push_rand(input int r);
    logic [7:0] a, b;
    logic sg;
    a = 8'($urandom); b = 8'($urandom); sg = 1'($urandom);
    push(r, a, b, sg, ref_mul(a, b, sg));
  endtask

  // One clock: drive from request queues, check at negedge, advance model.
  task automatic step();
    logic v0, v1, s2f, s1f, gv, gid, n_s1, n_s2;
    sb_t  e;
    op_t  o;
    v0 = (q0.size() > 0);
    v1 = (q1.size() > 0);
    req0_vld = v0;
    req1_vld = v1;
    if (v0) begin req0_a = q0[0].a; req0_b = q0[0].b; req0_signed = q0[0].sg; end
    if (v1) begin req1_a = q1[0].a; req1_b = q1[0].b; req1_signed = q1[0].sg; end
    @(negedge clk);
    if (rst) begin
      sb.delete();
      @(posedge clk); #1;
      m_s1 = 1'b0; m_s2 = 1'b0; m_last = 1'b1;
      cyc++;
      return;
    end
    s2f = !m_s2 || res_rdy;
    s1f = !m_s1 || s2f;
    gv = 1'b0; gid = 1'b0;
    if (s1f) begin
      if (v0 && v1) begin gv = 1'b1; gid = ~m_last; end
      else if (v0) begin gv = 1'b1; gid = 1'b0; end
      else if (v1) begin gv = 1'b1; gid = 1'b1; end
    end
    chk("rdy0", req0_rdy, gv && !gid);
    chk("rdy1", req1_rdy, gv && gid);
    chk("res_vld", res_vld, m_s2);
    if (m_s2 && sb.size() > 0) begin
      chk("res", res, sb[0].res);
      chk("res_id", res_id, sb[0].id);
      if (res_rdy) begin
        if (sb[0].lat) chk("latency", cyc - sb[0].acc, 2);
        void'(sb.pop_front());
      end
    end
    if (gv) begin
      o = gid ? q1.pop_front() : q0.pop_front();
      e.res = o.exp; e.id = gid; e.acc = cyc; e.lat = lat_mode;
      sb.push_back(e);
    end
    n_s2 = (s2f && m_s1) ? 1'b1 : (res_rdy ? 1'b0 : m_s2);
    n_s1 = gv ? 1'b1 : (s2f ? 1'b0 : m_s1);
    @(posedge clk); #1;
    m_s1 = n_s1; m_s2 = n_s2;
    if (gv) m_last = gid;
    cyc++;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && (q0.size() + q1.size() + sb.size()) > 0; k++) step();
    chk("drain_empty", q0.size() + q1.size() + sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; res_rdy = 1'b1;
    req0_vld = 1'b0; req0_a = 8'd0; req0_b = 8'd0; req0_signed = 1'b0;
    req1_vld = 1'b0; req1_a = 8'd0; req1_b = 8'd0; req1_signed = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_res_vld", res_vld, 1'b0);
    chk("rst_res", res, 16'h0000);
    chk("rst_res_id", res_id, 1'b0);

    // Directed single operations with hand-computed products.
    lat_mode = 1'b1;
    push(0, 8'hFF, 8'h02, 1'b1, 16'hFFFE); repeat (4) step();
    push(1, 8'hFF, 8'h02, 1'b0, 16'h01FE); repeat (4) step();
    push(0, 8'h80, 8'h80, 1'b1, 16'h4000); repeat (4) step();
    push(1, 8'h7F, 8'h80, 1'b1, 16'hC080); repeat (4) step();
    push(0, 8'hFF, 8'hFF, 1'b0, 16'hFE01); repeat (4) step();
    push(1, 8'h80, 8'h7F, 1'b0, 16'h3F80); repeat (4) step();

    // Both requesters continuously valid, no stall: alternating grants.
    for (int i = 0; i < 4; i++) begin push_rand(0); push_rand(1); end
    drain();

    // Backpressure while both stream.
    lat_mode = 1'b0;
    res_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin push_rand(0); push_rand(1); end
    repeat (5) step();
    chk("bp_rdy0_low", req0_rdy, 1'b0);
    chk("bp_rdy1_low", req1_rdy, 1'b0);
    chk("bp_res_vld", res_vld, 1'b1);
    res_rdy = 1'b1;
    drain();

    // Random traffic with random backpressure.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) != 0 && q0.size() < 3) push_rand(0);
      if ($urandom_range(0, 2) != 0 && q1.size() < 3) push_rand(1);
      res_rdy = 1'($urandom_range(0, 3) != 0);
      step();
    end
    res_rdy = 1'b1;
    drain();

    // Reset with both stages full: in-flight work must vanish.
    res_rdy = 1'b0;
    push_rand(0); push_rand(1); push_rand(0); push_rand(1);
    repeat (3) step();
    q0.delete(); q1.delete();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_res_vld", res_vld, 1'b0);
    chk("mid_rst_res", res, 16'h0000);
    res_rdy = 1'b1;
    push(0, 8'h03, 8'h05, 1'b0, 16'h000F);
    push(1, 8'hFE, 8'h03, 1'b1, 16'hFFFA);
    step();
    chk("tie_after_rst_q1_pending", q1.size(), 1);
    drain();
    repeat (6) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mul_rr_arbiter.md
Name: mul_rr_arbiter

Overview:
- Shares one signed_or_unsigned_mul datapath between two requesters (ports 0 and 1).
- Uses round-robin arbitration and valid/ready handshakes on every channel.
- Two-stage pipeline: an operand register, then a result register. Result is tagged with the requester id.
- Sits between two independent arithmetic clients and a single shared multiplier in the combinational-arithmetic exercise set.

Parameters:
n, 8, operand width; product width is 2*n

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req0_vld  input  1  requester 0 has an operation
req0_rdy  output  1  requester 0 operation accepted this cycle (vld & rdy)
req0_a  input  n  requester 0 operand a
req0_b  input  n  requester 0 operand b
req0_signed  input  1  requester 0: 1 = signed multiply, 0 = unsigned
req1_vld  input  1  requester 1 valid
req1_rdy  output  1  requester 1 accepted
req1_a  input  n  requester 1 operand a
req1_b  input  n  requester 1 operand b
req1_signed  input  1  requester 1 signed select
res_vld  output  1  result valid
res_rdy  input  1  consumer accepts result
res  output  2*n  product
res_id  output  1  requester id that issued the product

Behaviour:
- Reset (rst=1 at a clock edge):
  - s1_vld=0, res_vld=0, res=0, res_id=0.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
  - Reset mid-operation discards all in-flight operations; no result for them ever appears.
- Stage 2 (result register):
  - s2_free = !res_vld | res_rdy.
- Stage 1 (operand register, holds a, b, signed, id):
  - s1_free = !s1_vld | s2_free.
- Arbitration:
  - Combinational, evaluated only when s1_free=1.
  - Only one valid: that requester is granted.
  - Both valid: grant the requester != last.
  - On a grant, last <= granted id.
  - No grant: last is unchanged.
- Handshake outputs:
  - reqX_rdy = s1_free & granted==X.
  - At most one reqX_rdy is high per cycle.
  - rdy never depends on the same requester's operands, only on its vld.
- Requester obligations:
  - Once reqX_vld=1, the requester holds vld and operands stable until accepted.
  - The bench asserts this; the block does not check it.
- Stage 1 load:
  - On accept, s1 loads the granted operands and id, and s1_vld <= 1.
  - Else, if s2_free, s1_vld <= 0.
  - Else s1 holds.
- Stage 2 load:
  - If s2_free & s1_vld: res <= product(s1), res_id <= s1.id, res_vld <= 1.
  - Else, if res_rdy: res_vld <= 0.
  - Else hold; res and res_id stay stable while res_vld & !res_rdy.
- Arithmetic:
  - s1.signed=1: two's-complement product of sign-extended operands, full 2*n bits.
  - s1.signed=0: zero-extended product.
  - No truncation, no overflow possible.
- Latency and throughput:
  - Accept in cycle t gives res_vld in cycle t+2 when there is no backpressure.
  - Throughput is 1 operation/cycle with res_rdy held high.
- Backpressure:
  - res_rdy low with both stages full: s1_free=0, both req rdy low, nothing lost.
  - Stall released: pipeline advances the same cycle res_rdy goes high (no bubble).
- Ordering: results leave in acceptance order. Per-requester order is preserved.
- Fairness: with both requesters continuously valid and no stall, grants alternate 0,1,0,1...

Decomposition:
- Package mul_arb_pkg: typedef mul_op_t struct {a, b, signed_mul, id}, parameterized via n at use site or a localparam default; localparam N_REQ = 2.
- Sub-module: instantiate the existing signed_or_unsigned_mul (n) between stage 1 and stage 2; no new multiplier logic.
- Arbiter may be a small local always_comb; no separate module required.

Test Plan:
- n=8, reset, single op: req0 a=8'hFF b=8'h02 signed=1 -> 2 cycles later res=16'hFFFE, res_id=0.
- Same operands, signed=0 on req1 -> res=16'h01FE, res_id=1.
- Signed corner case: a=8'h80, b=8'h80, signed=1 -> res=16'h4000.
- Both requesters valid for 4 cycles, res_rdy=1:
  - accept order 0,1,0,1; res_id sequence 0,1,0,1.
  - exactly one rdy high per cycle.
- Backpressure: res_rdy=0 for 5 cycles while ops stream:
  - after 2 accepts, both rdy low.
  - res holds its value.
  - release -> no op lost or duplicated; results in order.
- Reset asserted with s1 and s2 both full -> next cycle res_vld=0; neither discarded op ever appears; the next tie grants requester 0.
